// File: rtl/fpu_bist_sequencer.sv
// Vector-replay self-test sequencer for fpu16: fetches packed vectors, drives the FPU,
// scores each result as pass/fail/skip and captures the first failure of a run.
module fpu_bist_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int ADD_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clock,
  input  logic                 resetN,
  input  logic                 go,
  input  logic [ADDR_W:0]      numVectors,
  input  logic                 stopOnFail,
  output logic [ADDR_W-1:0]    vecAddr,
  input  logic [3*WIDTH+1:0]   vecData,
  output logic [WIDTH-1:0]     fpuIn1,
  output logic [WIDTH-1:0]     fpuIn2,
  output logic [1:0]           op,
  output logic                 start,
  input  logic [WIDTH-1:0]     fpuOut,
  input  logic                 mulDone,
  input  logic [4:0]           statusFlags,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W:0]      passCount,
  output logic [ADDR_W:0]      failCount,
  output logic [ADDR_W:0]      skipCount,
  output logic                 firstFailValid,
  output logic [ADDR_W-1:0]    firstFailIdx,
  output logic [WIDTH-1:0]     firstFailGot,
  output logic                 timeoutErr
);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int WMAX   = (TIMEOUT > ADD_LAT) ? TIMEOUT : ADD_LAT;
  localparam int WAIT_W = $clog2(WMAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   index;
  logic [CNT_W-1:0]    num_reg;
  logic                stop_reg;
  logic [WIDTH-1:0]    exp_reg;
  logic                forced;
  logic                tmo_vec;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [WIDTH-1:0]    vec_in1, vec_in2, vec_exp;
  logic [1:0]          vec_op;
  logic [CNT_W-1:0]    num_clamped;
  logic                is_pass, is_skip, is_fail, is_last;
  logic                unused_flags;

  assign vec_in1 = vecData[3*WIDTH+1 -: WIDTH];
  assign vec_in2 = vecData[2*WIDTH+1 -: WIDTH];
  assign vec_op  = vecData[WIDTH+1 -: 2];
  assign vec_exp = vecData[WIDTH-1:0];

  assign num_clamped = (numVectors > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : numVectors;

  // Exactly one of pass/skip/fail holds in CHECK; NV only excuses an unforced mismatch.
  assign is_pass = !forced && (fpuOut == exp_reg);
  assign is_skip = !forced && !is_pass && statusFlags[4];
  assign is_fail = !is_pass && !is_skip;
  assign is_last = ({1'b0, index} == num_reg - CNT_W'(1));

  assign unused_flags = ^statusFlags[3:0];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state          <= S_IDLE;
      index          <= '0;
      num_reg        <= '0;
      stop_reg       <= 1'b0;
      exp_reg        <= '0;
      forced         <= 1'b0;
      tmo_vec        <= 1'b0;
      wait_cnt       <= '0;
      vecAddr        <= '0;
      fpuIn1         <= '0;
      fpuIn2         <= '0;
      op             <= '0;
      start          <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      passCount      <= '0;
      failCount      <= '0;
      skipCount      <= '0;
      firstFailValid <= 1'b0;
      firstFailIdx   <= '0;
      firstFailGot   <= '0;
      timeoutErr     <= 1'b0;
    end else begin
      done  <= 1'b0;
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            busy           <= 1'b1;
            passCount      <= '0;
            failCount      <= '0;
            skipCount      <= '0;
            firstFailValid <= 1'b0;
            firstFailIdx   <= '0;
            firstFailGot   <= '0;
            timeoutErr     <= 1'b0;
            stop_reg       <= stopOnFail;
            num_reg        <= num_clamped;
            index          <= '0;
            vecAddr        <= '0;
            // An empty run spends one extra DONE cycle before pulsing done.
            state          <= (numVectors == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state <= S_ISSUE;
        S_ISSUE: begin
          fpuIn1   <= vec_in1;
          fpuIn2   <= vec_in2;
          op       <= vec_op;
          exp_reg  <= vec_exp;
          wait_cnt <= '0;
          tmo_vec  <= 1'b0;
          if (vec_op == 2'd3) begin
            forced <= 1'b1;
            state  <= S_CHECK;
          end else begin
            forced <= 1'b0;
            start  <= (vec_op == 2'd2);
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (op == 2'd2) begin
            if (mulDone) begin
              state <= S_CHECK;
            end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
              timeoutErr <= 1'b1;
              forced     <= 1'b1;
              tmo_vec    <= 1'b1;
              state      <= S_CHECK;
            end else begin
              wait_cnt <= wait_cnt + WAIT_W'(1);
            end
          end else if (wait_cnt == WAIT_W'(ADD_LAT - 1)) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_CHECK: begin
          if (is_pass) passCount <= passCount + CNT_W'(1);
          if (is_skip) skipCount <= skipCount + CNT_W'(1);
          if (is_fail) begin
            failCount <= failCount + CNT_W'(1);
            if (!firstFailValid) begin
              firstFailValid <= 1'b1;
              firstFailIdx   <= index;
              firstFailGot   <= tmo_vec ? '0 : fpuOut;
            end
          end
          if (is_last || (is_fail && stop_reg)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            index   <= index + ADDR_W'(1);
            vecAddr <= index + ADDR_W'(1);
            state   <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_bist_sequencer.sv
// Directed bench for fpu_bist_sequencer: a table of runs over a table of vectors,
// with a behavioural vector memory and FPU stand-in, plus reset/abort sequences.
module tb_fpu_bist_sequencer;
  localparam int W = 16, D = 16, AW = 4, CW = 5, LAT = 2, TMO = 8, NVT = 32, NRUN = 10;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic go = 1'b0;
  logic [CW-1:0] numVectors = '0;
  logic stopOnFail = 1'b0;
  logic [AW-1:0] vecAddr;
  logic [3*W+1:0] vecData;
  logic [W-1:0] fpuIn1, fpuIn2, fpuOut;
  logic [1:0] op;
  logic start, mulDone, busy, done, firstFailValid, timeoutErr;
  logic [4:0] statusFlags;
  logic [CW-1:0] passCount, failCount, skipCount;
  logic [AW-1:0] firstFailIdx;
  logic [W-1:0] firstFailGot;

  always #5 clock = ~clock;

  fpu_bist_sequencer #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW), .ADD_LAT(LAT), .TIMEOUT(TMO)) dut (
    .clock(clock), .resetN(resetN), .go(go), .numVectors(numVectors), .stopOnFail(stopOnFail),
    .vecAddr(vecAddr), .vecData(vecData), .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .op(op),
    .start(start), .fpuOut(fpuOut), .mulDone(mulDone), .statusFlags(statusFlags),
    .busy(busy), .done(done), .passCount(passCount), .failCount(failCount),
    .skipCount(skipCount), .firstFailValid(firstFailValid), .firstFailIdx(firstFailIdx),
    .firstFailGot(firstFailGot), .timeoutErr(timeoutErr));

  typedef struct {
    logic [W-1:0] in1, in2; logic [1:0] vop; logic [W-1:0] expv, got; logic nv; int lat;
  } vec_t;
  typedef struct {
    string name; int first; int nvec; logic stop; int glitch;
    int pass_e, fail_e, skip_e; logic ffv_e; int ffidx_e; logic [W-1:0] ffgot_e;
    logic tmo_e; int edges_e; int starts_e;
  } run_t;

  vec_t vt[NVT];
  run_t runs[NRUN];
  logic [3*W+1:0] mem[D];
  logic [W-1:0] mgot[D];
  logic mnv[D];
  int mlat[D];
  logic [AW-1:0] cur_idx;
  int mcnt;
  int n_cmp = 0, n_err = 0;

  // Vector memory (one-cycle read) and an FPU stand-in returning a per-vector canned result.
  always @(posedge clock) begin
    vecData     <= mem[vecAddr];
    cur_idx     <= vecAddr;
    fpuOut      <= mgot[cur_idx];
    statusFlags <= {mnv[cur_idx], 4'b0};
  end

  // mulDone rises lat+1 cycles after the start cycle; lat=0 never completes.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      mcnt <= 0; mulDone <= 1'b0;
    end else if (start) begin
      mcnt <= mlat[cur_idx]; mulDone <= 1'b0;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1; mulDone <= (mcnt == 1);
    end else begin
      mulDone <= 1'b0;
    end
  end

  function automatic vec_t mk(input logic [W-1:0] a, b, input logic [1:0] o,
                              input logic [W-1:0] e, g, input logic nv, input int lat);
    vec_t v;
    v.in1 = a; v.in2 = b; v.vop = o; v.expv = e; v.got = g; v.nv = nv; v.lat = lat;
    return v;
  endfunction

  function automatic run_t mr(input string n, input int f, nv, input logic st, input int gl,
                              input int p, fl, sk, input logic ffv, input int ffi,
                              input logic [W-1:0] ffg, input logic tm, input int ed, stc);
    run_t r;
    r.name = n; r.first = f; r.nvec = nv; r.stop = st; r.glitch = gl;
    r.pass_e = p; r.fail_e = fl; r.skip_e = sk; r.ffv_e = ffv; r.ffidx_e = ffi;
    r.ffgot_e = ffg; r.tmo_e = tm; r.edges_e = ed; r.starts_e = stc;
    return r;
  endfunction

  task automatic chk(input string rn, input string what, input logic [79:0] got, input logic [79:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s/%s: got %0h, required %0h", rn, what, got, req);
    end
  endtask

  task automatic load(input int first);
    for (int i = 0; i < D; i++) begin
      int k;
      k = first + i;
      if (k < NVT) begin
        mem[i] = {vt[k].in1, vt[k].in2, vt[k].vop, vt[k].expv};
        mgot[i] = vt[k].got; mnv[i] = vt[k].nv; mlat[i] = vt[k].lat;
      end else begin
        mem[i] = '0; mgot[i] = '0; mnv[i] = 1'b0; mlat[i] = 0;
      end
    end
  endtask

  task automatic do_run(input int r);
    int edges, starts;
    bit seen;
    string rn;
    rn = runs[r].name;
    load(runs[r].first);
    @(negedge clock);
    numVectors = CW'(runs[r].nvec);
    stopOnFail = runs[r].stop;
    go = 1'b1;
    chk(rn, "busy_before_go", {79'd0, busy}, 80'd0);
    edges = 0; starts = 0; seen = 0;
    while (!seen && edges < 300) begin
      @(posedge clock); #1;
      edges++;
      go = (runs[r].glitch != 0 && edges == runs[r].glitch);
      if (edges == 1) chk(rn, "busy_after_go", {79'd0, busy}, 80'd1);
      if (start) starts++;
      if (done) seen = 1;
    end
    chk(rn, "done_seen", {79'd0, seen}, 80'd1);
    chk(rn, "edges_to_done", 80'(edges), 80'(runs[r].edges_e));
    chk(rn, "pass", 80'(passCount), 80'(runs[r].pass_e));
    chk(rn, "fail", 80'(failCount), 80'(runs[r].fail_e));
    chk(rn, "skip", 80'(skipCount), 80'(runs[r].skip_e));
    chk(rn, "ff_valid", {79'd0, firstFailValid}, {79'd0, runs[r].ffv_e});
    chk(rn, "ff_idx", 80'(firstFailIdx), 80'(runs[r].ffidx_e));
    chk(rn, "ff_got", 80'(firstFailGot), 80'(runs[r].ffgot_e));
    chk(rn, "timeout_err", {79'd0, timeoutErr}, {79'd0, runs[r].tmo_e});
    chk(rn, "start_cycles", 80'(starts), 80'(runs[r].starts_e));
    @(posedge clock); #1;
    chk(rn, "done_one_cycle", {78'd0, done, busy}, 80'd0);
    $display("run %s: edges=%0d pass=%0d fail=%0d skip=%0d ffidx=%0d ffgot=%h tmo=%0d",
             rn, edges, passCount, failCount, skipCount, firstFailIdx, firstFailGot, timeoutErr);
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({busy, done, start, firstFailValid, timeoutErr, vecAddr, fpuIn1, fpuIn2, op,
                passCount, failCount, skipCount, firstFailIdx, firstFailGot});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, done_hits;
    bit got_start;
    vt[0]  = mk(16'h3C00, 16'h4000, 2'd0, 16'h4200, 16'h4200, 1'b0, 0);
    vt[1]  = mk(16'h4400, 16'h3C00, 2'd1, 16'h4200, 16'h4200, 1'b0, 0);
    vt[2]  = mk(16'h4000, 16'h4000, 2'd2, 16'h4400, 16'h4400, 1'b0, 5);
    vt[3]  = mk(16'h3C00, 16'h3C00, 2'd0, 16'h4000, 16'h3C00, 1'b0, 0);
    vt[4]  = mk(16'h7E00, 16'h3C00, 2'd0, 16'h7E00, 16'h0000, 1'b1, 0);
    vt[5]  = mk(16'h4000, 16'h4000, 2'd2, 16'h4400, 16'h1234, 1'b0, 0);
    vt[6]  = mk(16'h3C00, 16'h3C00, 2'd0, 16'h4000, 16'h4000, 1'b0, 0);
    vt[7]  = mk(16'h4000, 16'h3C00, 2'd0, 16'h4200, 16'h4100, 1'b0, 0);
    vt[8]  = mk(16'h4000, 16'h4000, 2'd0, 16'h4400, 16'h4400, 1'b0, 0);
    vt[9]  = mk(16'h4400, 16'h4000, 2'd1, 16'h4000, 16'h4000, 1'b0, 0);
    vt[10] = mk(16'h3C00, 16'h0000, 2'd0, 16'h3C00, 16'h3C00, 1'b0, 0);
    vt[11] = mk(16'h1111, 16'h2222, 2'd3, 16'h1111, 16'h1111, 1'b0, 0);
    vt[12] = mk(16'h0001, 16'h0001, 2'd0, 16'h0002, 16'h0001, 1'b0, 0);
    vt[13] = mk(16'h0002, 16'h0002, 2'd0, 16'h0004, 16'h0003, 1'b0, 0);
    vt[14] = mk(16'h0000, 16'h0000, 2'd0, 16'h0000, 16'h0000, 1'b0, 0);
    vt[15] = mk(16'h0000, 16'h0000, 2'd0, 16'h0000, 16'h0000, 1'b0, 0);
    for (int i = 16; i < NVT; i++) begin
      vt[i] = mk(16'(i), 16'h0100, 2'd0, 16'(i + 16'h0100), 16'(i + 16'h0100), 1'b0, 0);
    end

    //                 name        first nvec stop glitch pass fail skip ffv idx ffgot    tmo edges starts
    runs[0] = mr("add1",         0,  1, 1'b0, 0,  1, 0, 0, 1'b0, 0, 16'h0000, 1'b0,  6, 0);
    runs[1] = mr("mix4",         1,  4, 1'b0, 0,  2, 1, 1, 1'b1, 2, 16'h3C00, 1'b0, 26, 1);
    runs[2] = mr("mul_timeout",  5,  1, 1'b0, 0,  0, 1, 0, 1'b1, 0, 16'h0000, 1'b1, 12, 1);
    runs[3] = mr("stop_on_fail", 6,  5, 1'b1, 0,  1, 1, 0, 1'b1, 1, 16'h4100, 1'b0, 11, 0);
    runs[4] = mr("no_stop",      6,  5, 1'b0, 0,  4, 1, 0, 1'b1, 1, 16'h4100, 1'b0, 26, 0);
    runs[5] = mr("reserved_op", 11,  1, 1'b0, 0,  0, 1, 0, 1'b1, 0, 16'h1111, 1'b0,  4, 0);
    runs[6] = mr("two_fails",   12,  2, 1'b0, 0,  0, 2, 0, 1'b1, 0, 16'h0001, 1'b0, 11, 0);
    runs[7] = mr("clamp17",     16, 17, 1'b0, 0, 16, 0, 0, 1'b0, 0, 16'h0000, 1'b0, 81, 0);
    runs[8] = mr("zero",         0,  0, 1'b0, 0,  0, 0, 0, 1'b0, 0, 16'h0000, 1'b0,  2, 0);
    runs[9] = mr("go_midrun",    0,  1, 1'b0, 3,  1, 0, 0, 1'b0, 0, 16'h0000, 1'b0,  6, 0);

    load(0);
    repeat (3) @(posedge clock);
    #1 chk("reset", "all_outputs", all_outs(), 80'd0);
    @(negedge clock) resetN = 1'b1;
    repeat (2) @(posedge clock);

    for (int r = 0; r < NRUN; r++) do_run(r);

    // Abort a MUL in WAIT with an asynchronous reset mid-cycle.
    load(5);
    @(negedge clock);
    numVectors = CW'(1); stopOnFail = 1'b0; go = 1'b1;
    waited = 0; got_start = 0;
    while (!got_start && waited < 20) begin
      @(posedge clock); #1;
      go = 1'b0; waited++;
      if (start) got_start = 1;
    end
    chk("abort", "start_seen", {79'd0, got_start}, 80'd1);
    chk("abort", "operand_driven", 80'(fpuIn1), 80'h4000);
    @(negedge clock);
    resetN = 1'b0;
    #1 chk("abort", "all_outputs", all_outs(), 80'd0);
    @(negedge clock) resetN = 1'b1;
    done_hits = 0;
    repeat (15) begin
      @(posedge clock); #1;
      if (done) done_hits++;
    end
    chk("abort", "no_done", 80'(done_hits), 80'd0);
    $display("run abort: reset during MUL WAIT, done pulses afterwards=%0d", done_hits);
    do_run(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
